token_issuer: RTL and testbench

//  Parametrised parking-token issuer: successor to the combinational park_number^pattern token XOR.

---
 rtl/token_issuer.sv | 122 ++++++++++++
 tb/tb_token_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/token_issuer.sv
// Parking-token issuer: grants lowest free slot with token = slot ^ pattern, verifies slot/token on exit.
// Ack one edge after the request is taken; held requests wait in DONE until both drop. Optional TOKEN_LFSR_EN.
module token_issuer #(
  parameter int                SLOT_W    = 3,
  parameter int                NUM_SLOTS = 8,
  parameter logic [SLOT_W-1:0] SEED      = 3'b101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_req,
  output logic              entry_ack,
  output logic              entry_ok,
  output logic [SLOT_W-1:0] entry_slot,
  output logic [SLOT_W-1:0] entry_token,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  input  logic [SLOT_W-1:0] exit_token,
  output logic              exit_ack,
  output logic              exit_ok,
  output logic [SLOT_W:0]   count,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, ENTRY, EXIT, DONE} state_t;

  localparam logic [SLOT_W:0] SLOTS_MAX = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W:0] ONE       = (SLOT_W+1)'(1);

  state_t               state;
  logic [NUM_SLOTS-1:0] occupied;
  logic [SLOT_W-1:0]    tok_mem [NUM_SLOTS];
  logic                 free_found;
  logic [SLOT_W-1:0]    free_slot;
  logic                 exit_match;

`ifdef TOKEN_LFSR_EN
  logic [SLOT_W-1:0] pattern;
`else
  localparam logic [SLOT_W-1:0] pattern = SEED;
`endif

  // Scan downward so the last hit is the lowest-numbered free slot.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    exit_match = 1'b0;
    if ({1'b0, exit_slot} < SLOTS_MAX)
      exit_match = occupied[exit_slot] && (tok_mem[exit_slot] == exit_token);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      occupied    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) tok_mem[i] <= '0;
      count       <= '0;
      full        <= 1'b0;
      entry_ack   <= 1'b0;
      entry_ok    <= 1'b0;
      entry_slot  <= '0;
      entry_token <= '0;
      exit_ack    <= 1'b0;
      exit_ok     <= 1'b0;
`ifdef TOKEN_LFSR_EN
      pattern     <= SEED;
`endif
    end else begin
      entry_ack   <= 1'b0;
      entry_ok    <= 1'b0;
      entry_slot  <= '0;
      entry_token <= '0;
      exit_ack    <= 1'b0;
      exit_ok     <= 1'b0;
      case (state)
        IDLE: begin
          if (exit_req)       state <= EXIT;
          else if (entry_req) state <= ENTRY;
        end
        ENTRY: begin
          state     <= DONE;
          entry_ack <= 1'b1;
          if (free_found) begin
            entry_ok           <= 1'b1;
            entry_slot         <= free_slot;
            entry_token        <= free_slot ^ pattern;
            tok_mem[free_slot] <= free_slot ^ pattern;
            occupied[free_slot] <= 1'b1;
            count              <= count + ONE;
            full               <= (count + ONE) == SLOTS_MAX;
`ifdef TOKEN_LFSR_EN
            pattern <= {pattern[SLOT_W-2:0], pattern[SLOT_W-1] ^ pattern[SLOT_W-2]};
`endif
          end
        end
        EXIT: begin
          state    <= DONE;
          exit_ack <= 1'b1;
          if (exit_match) begin
            exit_ok             <= 1'b1;
            occupied[exit_slot] <= 1'b0;
            count               <= count - ONE;
            full                <= 1'b0;
          end
        end
        DONE: begin
          if (!entry_req && !exit_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_issuer.sv
// Scoreboard bench for token_issuer: a reference model pushes expected acks, the monitor pops on each ack.
module tb_token_issuer;
  localparam int SLOT_W = 3;
  localparam int NUM_SLOTS = 8;
  localparam logic [SLOT_W-1:0] SEED = 3'b101;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              entry_req = 1'b0;
  logic              entry_ack, entry_ok;
  logic [SLOT_W-1:0] entry_slot, entry_token;
  logic              exit_req = 1'b0;
  logic [SLOT_W-1:0] exit_slot = '0, exit_token = '0;
  logic              exit_ack, exit_ok;
  logic [SLOT_W:0]   count;
  logic              full;

  token_issuer #(.SLOT_W(SLOT_W), .NUM_SLOTS(NUM_SLOTS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .entry_ack(entry_ack), .entry_ok(entry_ok),
    .entry_slot(entry_slot), .entry_token(entry_token),
    .exit_req(exit_req), .exit_slot(exit_slot), .exit_token(exit_token),
    .exit_ack(exit_ack), .exit_ok(exit_ok), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_entry;
    bit          ok;
    logic [2:0]  slot;
    logic [2:0]  token;
    int          cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         m_occ [NUM_SLOTS];
  logic [2:0] m_tok [NUM_SLOTS];
  logic [2:0] m_pat;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_occ[i] = 1'b0;
      m_tok[i] = '0;
    end
    m_pat = SEED;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_entry();
    exp_t e;
    e = '{is_entry: 1'b1, ok: 1'b0, slot: 3'd0, token: 3'd0, cnt: 0};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!m_occ[i] && !e.ok) begin
        e.ok = 1'b1;
        e.slot = 3'(i);
        e.token = 3'(i) ^ m_pat;
        m_occ[i] = 1'b1;
        m_tok[i] = e.token;
        m_cnt++;
`ifdef TOKEN_LFSR_EN
        m_pat = {m_pat[1:0], m_pat[2] ^ m_pat[1]};
`endif
      end
    end
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic model_exit(input logic [2:0] s, input logic [2:0] t);
    exp_t e;
    e = '{is_entry: 1'b0, ok: 1'b0, slot: 3'd0, token: 3'd0, cnt: 0};
    if (int'(s) < NUM_SLOTS && m_occ[s] && m_tok[s] == t) begin
      e.ok = 1'b1;
      m_occ[s] = 1'b0;
      m_cnt--;
    end
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // Waits at negedges for the requested ack; flags the other ack or a timeout.
  task automatic wait_ack(input bit want_entry, output int lat, output bit found);
    found = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (want_entry ? exit_ack : entry_ack) check("wrong_ack", 1, 0);
      if (want_entry ? entry_ack : exit_ack) found = 1'b1;
    end
    if (!found) check("ack_timeout", 0, 1);
  endtask

  task automatic compare_ack();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (e.is_entry) begin
      check("entry_ok", entry_ok, e.ok);
      check("entry_slot", entry_slot, e.slot);
      check("entry_token", entry_token, e.token);
    end else begin
      check("exit_ok", exit_ok, e.ok);
    end
    check("count", count, e.cnt);
    check("full", full, e.cnt == NUM_SLOTS);
  endtask

  task automatic do_entry(output logic [2:0] s, output logic [2:0] t, output logic ok);
    int lat;
    bit found;
    entry_req = 1'b1;
    model_entry();
    wait_ack(1'b1, lat, found);
    s = entry_slot;
    t = entry_token;
    ok = entry_ok;
    if (found) begin
      check("entry_latency", lat, 2);
      compare_ack();
      @(negedge clk);
      check("entry_ack_pulse", entry_ack, 0);
      check("entry_slot_zeroed", entry_slot, 0);
    end
    entry_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_exit(input logic [2:0] s, input logic [2:0] t);
    int lat;
    bit found;
    exit_slot = s;
    exit_token = t;
    exit_req = 1'b1;
    model_exit(s, t);
    wait_ack(1'b0, lat, found);
    if (found) begin
      check("exit_latency", lat, 2);
      compare_ack();
      @(negedge clk);
      check("exit_ack_pulse", exit_ack, 0);
    end
    exit_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] s, t;
    logic       ok;
    int         lat;
    bit         found, saw_entry;

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_acks", {entry_ack, exit_ack, entry_ok, exit_ok}, 0);
    rst = 1'b0;
    @(negedge clk);

    // First two entries, including the known token values for SEED=101.
    do_entry(s, t, ok);
    check("first_slot", s, 3'b000);
    check("first_token", t, 3'b101);
    do_entry(s, t, ok);
    check("second_slot", s, 3'b001);
`ifdef TOKEN_LFSR_EN
    check("second_token", t, 3'b010);
`else
    check("second_token", t, 3'b100);
`endif

    // Fill the lot, then one more entry must be refused.
    for (int i = 2; i < NUM_SLOTS; i++) do_entry(s, t, ok);
    check("full_at_8", full, 1);
    do_entry(s, t, ok);
    check("overflow_refused", ok, 0);
    check("overflow_count", count, NUM_SLOTS);

    // Exit paths: good token, repeat of the same, wrong token.
    do_exit(3'd0, m_tok[0]);
    do_exit(3'd0, m_tok[0]);
    do_exit(3'd1, m_tok[1] ^ 3'b001);
    check("after_exits_count", count, NUM_SLOTS - 1);

    // Simultaneous requests: exit first, entry only after both drop and entry re-raises.
    entry_req = 1'b1;
    exit_slot = 3'd1;
    exit_token = m_tok[1];
    exit_req = 1'b1;
    model_exit(3'd1, m_tok[1]);
    wait_ack(1'b0, lat, found);
    if (found) compare_ack();
    saw_entry = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (entry_ack) saw_entry = 1'b1;
    end
    check("held_entry_not_served", saw_entry, 0);
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(negedge clk);
    do_entry(s, t, ok);
    check("deferred_entry_slot", s, 3'd0);

    // Reset while in ENTRY: no ack, lot cleared, fresh allocation afterwards.
    entry_req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    entry_req = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_count", count, 0);
    check("midrst_full", full, 0);
    rst = 1'b0;
    saw_entry = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (entry_ack) saw_entry = 1'b1;
    end
    check("midrst_no_ack", saw_entry, 0);
    do_entry(s, t, ok);
    check("post_rst_slot", s, 3'b000);
    check("post_rst_token", t, 3'b101);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
